// File: rtl/wb_stage.sv
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back pipeline stage. Captures a retiring instruction from
//            MEM, waits for load data when the memory is slow, then presents
//            a one-cycle register-file write strobe with index and data.
//            All write-side outputs come straight from flops, so they are
//            stable across the falling edge used by the register file.
// Ports    : clk, rst (async, active-high)
//            valid_in, freeze, wb_en_in, mem_r_en_in, alu_result_in[31:0],
//            dest_in[3:0]                     - instruction from MEM stage
//            mem_rdata[31:0], mem_ready       - data memory read return
//            stall                            - hold upstream (WAIT_MEM)
//            writeBackEn, Dest_wb[3:0], Result_WB[31:0] - register write
//            fwd_valid, fwd_dest[3:0], fwd_value[31:0]  - only with WB_FWD_EN
// Config   : `define WB_FWD_EN adds a one-cycle registered copy of each
//            retired write for forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        freeze,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic [31:0] alu_result_in,
   input  logic [3:0]  dest_in,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall,
   output logic        writeBackEn,
   output logic [3:0]  Dest_wb,
   output logic [31:0] Result_WB
`ifdef WB_FWD_EN
   ,
   output logic        fwd_valid,
   output logic [3:0]  fwd_dest,
   output logic [31:0] fwd_value
`endif
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_WRITE    = 2'd2
   } state_t;

   state_t      state;

   // Captured instruction fields, needed while waiting for load data.
   logic        wb_en_q;
   logic        load_q;
   logic [31:0] alu_q;
   logic [3:0]  dest_q;

   logic        capture;

   // WAIT_MEM ignores valid_in/freeze entirely.
   assign capture = (state != S_WAIT_MEM) && valid_in && !freeze;
   assign stall   = (state == S_WAIT_MEM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         wb_en_q     <= 1'b0;
         load_q      <= 1'b0;
         alu_q       <= 32'd0;
         dest_q      <= 4'd0;
         writeBackEn <= 1'b0;
         Dest_wb     <= 4'd0;
         Result_WB   <= 32'd0;
      end else begin
         // Strobe is a single-cycle pulse; only a transition into WRITE sets it.
         writeBackEn <= 1'b0;
         case (state)
            S_IDLE, S_WRITE: begin
               if (capture) begin
                  wb_en_q <= wb_en_in;
                  load_q  <= mem_r_en_in;
                  alu_q   <= alu_result_in;
                  dest_q  <= dest_in;
                  if (!mem_r_en_in) begin
                     state       <= S_WRITE;
                     writeBackEn <= wb_en_in;
                     Dest_wb     <= dest_in;
                     Result_WB   <= alu_result_in;
                  end else if (mem_ready) begin
                     // Result_WB doubles as the load-data latch.
                     state       <= S_WRITE;
                     writeBackEn <= wb_en_in;
                     Dest_wb     <= dest_in;
                     Result_WB   <= mem_rdata;
                  end else begin
                     state <= S_WAIT_MEM;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT_MEM: begin
               if (mem_ready) begin
                  state       <= S_WRITE;
                  writeBackEn <= wb_en_q;
                  Dest_wb     <= dest_q;
                  Result_WB   <= load_q ? mem_rdata : alu_q;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef WB_FWD_EN
   // Registered copy of the write that retires on this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_valid <= 1'b0;
         fwd_dest  <= 4'd0;
         fwd_value <= 32'd0;
      end else begin
         fwd_valid <= (state == S_WRITE) && writeBackEn;
         if ((state == S_WRITE) && writeBackEn) begin
            fwd_dest  <= Dest_wb;
            fwd_value <= Result_WB;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage. Each scenario task
//            drives inputs just after a rising edge and checks the packed
//            output vector {stall, writeBackEn, Dest_wb, Result_WB} 1 ns
//            after the following rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic        freeze = 1'b0;
   logic        wb_en_in = 1'b0;
   logic        mem_r_en_in = 1'b0;
   logic [31:0] alu_result_in = 32'd0;
   logic [3:0]  dest_in = 4'd0;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ready = 1'b0;
   logic        stall;
   logic        writeBackEn;
   logic [3:0]  Dest_wb;
   logic [31:0] Result_WB;
`ifdef WB_FWD_EN
   logic        fwd_valid;
   logic [3:0]  fwd_dest;
   logic [31:0] fwd_value;
`endif

   logic [37:0] obs;
   assign obs = {stall, writeBackEn, Dest_wb, Result_WB};

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .freeze       (freeze),
      .wb_en_in     (wb_en_in),
      .mem_r_en_in  (mem_r_en_in),
      .alu_result_in(alu_result_in),
      .dest_in      (dest_in),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .stall        (stall),
      .writeBackEn  (writeBackEn),
      .Dest_wb      (Dest_wb),
      .Result_WB    (Result_WB)
`ifdef WB_FWD_EN
      ,
      .fwd_valid    (fwd_valid),
      .fwd_dest     (fwd_dest),
      .fwd_value    (fwd_value)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      n_checks++;
      if (obs !== 38'd0) $display("FAIL reset_outputs: got %h want %h", obs, 38'd0);
      else n_pass++;
`ifdef WB_FWD_EN
      n_checks++;
      if ({fwd_valid, fwd_dest, fwd_value} !== 37'd0)
         $display("FAIL reset_fwd: got %h want %h", {fwd_valid, fwd_dest, fwd_value}, 37'd0);
      else n_pass++;
`endif
      rst = 1'b0;
   endtask

   task automatic test_alu_write;
      valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; dest_in = 4'd3; alu_result_in = 32'h0000_00AA;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd3, 32'h0000_00AA}) $display("FAIL alu_pulse: got %h want %h", obs, {1'b0, 1'b1, 4'd3, 32'h0000_00AA});
      else n_pass++;
      valid_in = 0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd3, 32'h0000_00AA}) $display("FAIL alu_after: got %h want %h", obs, {1'b0, 1'b0, 4'd3, 32'h0000_00AA});
      else n_pass++;
   endtask

   task automatic test_load_wait;
      valid_in = 1; wb_en_in = 1; mem_r_en_in = 1; dest_in = 4'd5; alu_result_in = 32'h100; mem_ready = 0;
      tick();
      n_checks++;
      if (obs !== {1'b1, 1'b0, 4'd3, 32'h0000_00AA}) $display("FAIL load_wait1: got %h want %h", obs, {1'b1, 1'b0, 4'd3, 32'h0000_00AA});
      else n_pass++;
      // a different instruction presented while waiting must be ignored
      mem_r_en_in = 0; dest_in = 4'd9; alu_result_in = 32'h99;
      tick();
      n_checks++;
      if (obs !== {1'b1, 1'b0, 4'd3, 32'h0000_00AA}) $display("FAIL load_wait2: got %h want %h", obs, {1'b1, 1'b0, 4'd3, 32'h0000_00AA});
      else n_pass++;
      mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF}) $display("FAIL load_pulse: got %h want %h", obs, {1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF});
      else n_pass++;
      valid_in = 0; mem_ready = 0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd5, 32'hDEAD_BEEF}) $display("FAIL load_after: got %h want %h", obs, {1'b0, 1'b0, 4'd5, 32'hDEAD_BEEF});
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; dest_in = 4'd1; alu_result_in = 32'h11;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd1, 32'h11}) $display("FAIL b2b_first: got %h want %h", obs, {1'b0, 1'b1, 4'd1, 32'h11});
      else n_pass++;
      dest_in = 4'd2; alu_result_in = 32'h22;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd2, 32'h22}) $display("FAIL b2b_second: got %h want %h", obs, {1'b0, 1'b1, 4'd2, 32'h22});
      else n_pass++;
      // load with data ready at capture, to r15
      mem_r_en_in = 1; mem_ready = 1; mem_rdata = 32'hCAFE_F00D; dest_in = 4'd15; alu_result_in = 32'h55;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd15, 32'hCAFE_F00D}) $display("FAIL b2b_load_r15: got %h want %h", obs, {1'b0, 1'b1, 4'd15, 32'hCAFE_F00D});
      else n_pass++;
      valid_in = 0; mem_ready = 0; mem_r_en_in = 0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd15, 32'hCAFE_F00D}) $display("FAIL b2b_after: got %h want %h", obs, {1'b0, 1'b0, 4'd15, 32'hCAFE_F00D});
      else n_pass++;
   endtask

   task automatic test_freeze_nowrite;
      valid_in = 1; wb_en_in = 0; mem_r_en_in = 0; dest_in = 4'd6; alu_result_in = 32'h66;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd6, 32'h66}) $display("FAIL nowrite: got %h want %h", obs, {1'b0, 1'b0, 4'd6, 32'h66});
      else n_pass++;
      freeze = 1; wb_en_in = 1; dest_in = 4'd8; alu_result_in = 32'h88;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (obs !== {1'b0, 1'b0, 4'd6, 32'h66}) $display("FAIL freeze_edge%0d: got %h want %h", i, obs, {1'b0, 1'b0, 4'd6, 32'h66});
         else n_pass++;
      end
      freeze = 0; valid_in = 0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd6, 32'h66}) $display("FAIL freeze_release: got %h want %h", obs, {1'b0, 1'b0, 4'd6, 32'h66});
      else n_pass++;
      // freeze while in WRITE: no capture, no repeated pulse
      valid_in = 1; dest_in = 4'd4; alu_result_in = 32'h44;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd4, 32'h44}) $display("FAIL freeze_write_pulse: got %h want %h", obs, {1'b0, 1'b1, 4'd4, 32'h44});
      else n_pass++;
      freeze = 1;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd4, 32'h44}) $display("FAIL freeze_in_write: got %h want %h", obs, {1'b0, 1'b0, 4'd4, 32'h44});
      else n_pass++;
      freeze = 0; valid_in = 0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd4, 32'h44}) $display("FAIL freeze_no_repeat: got %h want %h", obs, {1'b0, 1'b0, 4'd4, 32'h44});
      else n_pass++;
   endtask

   task automatic test_reset_mid_load;
      valid_in = 1; wb_en_in = 1; mem_r_en_in = 1; dest_in = 4'd5; alu_result_in = 32'd0; mem_ready = 0;
      tick();
      n_checks++;
      if (obs !== {1'b1, 1'b0, 4'd4, 32'h44}) $display("FAIL rst_load_wait: got %h want %h", obs, {1'b1, 1'b0, 4'd4, 32'h44});
      else n_pass++;
      valid_in = 0;
      #2 rst = 1;
      #1;
      n_checks++;
      if (obs !== 38'd0) $display("FAIL rst_async_clear: got %h want %h", obs, 38'd0);
      else n_pass++;
      mem_ready = 1; mem_rdata = 32'h1234_5678;
      tick();
      rst = 0;
      tick();
      n_checks++;
      if (obs !== 38'd0) $display("FAIL rst_no_write1: got %h want %h", obs, 38'd0);
      else n_pass++;
      tick();
      n_checks++;
      if (obs !== 38'd0) $display("FAIL rst_no_write2: got %h want %h", obs, 38'd0);
      else n_pass++;
      mem_ready = 0; mem_r_en_in = 0;
   endtask

   task automatic test_reset_in_write;
      valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; dest_in = 4'd10; alu_result_in = 32'hA0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd10, 32'hA0}) $display("FAIL rstw_pulse: got %h want %h", obs, {1'b0, 1'b1, 4'd10, 32'hA0});
      else n_pass++;
      rst = 1;
      #1;
      n_checks++;
      if (obs !== 38'd0) $display("FAIL rstw_clear: got %h want %h", obs, 38'd0);
      else n_pass++;
      tick();
      rst = 0;
      // first capture on the first edge after release
      dest_in = 4'd12; alu_result_in = 32'hC0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd12, 32'hC0}) $display("FAIL first_capture: got %h want %h", obs, {1'b0, 1'b1, 4'd12, 32'hC0});
      else n_pass++;
      valid_in = 0;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b0, 4'd12, 32'hC0}) $display("FAIL first_capture_after: got %h want %h", obs, {1'b0, 1'b0, 4'd12, 32'hC0});
      else n_pass++;
   endtask

`ifdef WB_FWD_EN
   task automatic test_fwd;
      valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; dest_in = 4'd7; alu_result_in = 32'h1234;
      tick();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 4'd7, 32'h1234}) $display("FAIL fwd_pulse: got %h want %h", obs, {1'b0, 1'b1, 4'd7, 32'h1234});
      else n_pass++;
      valid_in = 0;
      tick();
      n_checks++;
      if ({fwd_valid, fwd_dest, fwd_value} !== {1'b1, 4'd7, 32'h1234})
         $display("FAIL fwd_copy: got %h want %h", {fwd_valid, fwd_dest, fwd_value}, {1'b1, 4'd7, 32'h1234});
      else n_pass++;
      tick();
      n_checks++;
      if (fwd_valid !== 1'b0) $display("FAIL fwd_drop: got %b want %b", fwd_valid, 1'b0);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_alu_write();
      test_load_wait();
      test_back_to_back();
      test_freeze_nowrite();
      test_reset_mid_load();
      test_reset_in_write();
`ifdef WB_FWD_EN
      test_fwd();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
